// File: rtl/beta_ext_int_arbiter.sv
// Purpose : external interrupt arbiter; syncs sources, latches level/edge pending, picks lowest enabled id.
// Latency : src_i to ext_irq_o is SyncStages+1 edges; claim_i to claim_valid_o/claim_id_o is 1 edge.
// Backpr. : none; every claim is answered the next cycle (id 0 when nothing is eligible).
//
// Ports:
//   clk_i, rstn_i           core clock, synchronous active-low reset
//   src_i                   asynchronous interrupt lines, bit i-1 is source id i
//   cfg_we_i/addr/wdata     register writes: 0 ENABLE, 1 EDGE, 2 PENDING (OR-in), 3 INSERVICE (read-only)
//   cfg_rdata_o             combinational read of the register selected by cfg_addr_i
//   claim_i                 claim request; claim_valid_o pulses next cycle with claim_id_o
//   complete_i/complete_id_i retire an in-service id
//   ext_irq_o               registered OR of eligible sources
module beta_ext_int_arbiter #(
    parameter int NumSrc     = 8,
    parameter int IdWidth    = 4,
    parameter int SyncStages = 2
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [NumSrc-1:0]  src_i,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_addr_i,
    input  logic [NumSrc-1:0]  cfg_wdata_i,
    output logic [NumSrc-1:0]  cfg_rdata_o,
    input  logic               claim_i,
    output logic               claim_valid_o,
    output logic [IdWidth-1:0] claim_id_o,
    input  logic               complete_i,
    input  logic [IdWidth-1:0] complete_id_i,
    output logic               ext_irq_o
);

    logic [NumSrc-1:0]  sync_q [SyncStages];
    logic [NumSrc-1:0]  s;
    logic [NumSrc-1:0]  s_q;
    logic [NumSrc-1:0]  rise;

    logic [NumSrc-1:0]  enable_q, enable_d;
    logic [NumSrc-1:0]  edge_q, edge_d;
    logic [NumSrc-1:0]  pending_q, pending_d;
    logic [NumSrc-1:0]  inservice_q, inservice_d;

    logic [NumSrc-1:0]  eligible;
    logic [NumSrc-1:0]  win_oh;
    logic [IdWidth-1:0] win_id;
    logic [NumSrc-1:0]  claim_oh;
    logic [NumSrc-1:0]  cmp_oh;
    logic [NumSrc-1:0]  mode_chg;
    logic [NumSrc-1:0]  sw_set;
    logic [NumSrc-1:0]  level_set;
    logic [NumSrc-1:0]  edge_set;

    logic               claim_valid_q;
    logic [IdWidth-1:0] claim_id_q;
    logic               ext_irq_q;

    assign s        = sync_q[SyncStages-1];
    assign rise     = s & ~s_q;
    assign eligible = pending_q & enable_q & ~inservice_q;

    // Fixed priority: walk from the top so the lowest set bit is the last one written.
    always_comb begin
        win_oh = '0;
        win_id = '0;
        for (int i = NumSrc - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_id    = IdWidth'(i + 1);
            end
        end
    end

    assign claim_oh = claim_i ? win_oh : '0;

    // Only an id that is actually in service can be retired; 0 and out-of-range ids match nothing.
    always_comb begin
        cmp_oh = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (complete_i && (complete_id_i == IdWidth'(i + 1))) begin
                cmp_oh[i] = inservice_q[i];
            end
        end
    end

    always_comb begin
        enable_d = enable_q;
        edge_d   = edge_q;
        mode_chg = '0;
        sw_set   = '0;
        if (cfg_we_i) begin
            case (cfg_addr_i)
                2'd0: enable_d = cfg_wdata_i;
                2'd1: begin
                    edge_d   = cfg_wdata_i;
                    mode_chg = edge_q ^ cfg_wdata_i;
                end
                2'd2: sw_set = cfg_wdata_i;
                default: ;
            endcase
        end
        // A level source being claimed this edge must not immediately re-pend;
        // it is blocked from then on by INSERVICE.
        level_set   = s & ~edge_q & ~inservice_q & ~claim_oh;
        edge_set    = rise & edge_q;
        // Sets beat the claim's clear; a mode flip discards whatever is pending on that bit.
        pending_d   = ((pending_q & ~claim_oh) | level_set | edge_set | sw_set) & ~mode_chg;
        // Claim's set is applied after complete's clear so it wins on the same id.
        inservice_d = (inservice_q & ~cmp_oh) | claim_oh;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int j = 0; j < SyncStages; j++) begin
                sync_q[j] <= '0;
            end
            s_q           <= '0;
            enable_q      <= '0;
            edge_q        <= '0;
            pending_q     <= '0;
            inservice_q   <= '0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
            ext_irq_q     <= 1'b0;
        end else begin
            sync_q[0] <= src_i;
            for (int j = 1; j < SyncStages; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
            s_q           <= s;
            enable_q      <= enable_d;
            edge_q        <= edge_d;
            pending_q     <= pending_d;
            inservice_q   <= inservice_d;
            claim_valid_q <= claim_i;
            if (claim_i) begin
                claim_id_q <= win_id;
            end
            ext_irq_q     <= |eligible;
        end
    end

    always_comb begin
        cfg_rdata_o = '0;
        case (cfg_addr_i)
            2'd0:    cfg_rdata_o = enable_q;
            2'd1:    cfg_rdata_o = edge_q;
            2'd2:    cfg_rdata_o = pending_q;
            default: cfg_rdata_o = inservice_q;
        endcase
    end

    assign claim_valid_o = claim_valid_q;
    assign claim_id_o    = claim_id_q;
    assign ext_irq_o     = ext_irq_q;

endmodule

// File: doc/beta_ext_int_arbiter.md
# beta_ext_int_arbiter

External interrupt arbiter in front of the trap control unit. It synchronizes up to `NumSrc` asynchronous interrupt lines and latches them as level- or edge-triggered pending bits. It arbitrates enabled pending sources by fixed priority and drives the single machine external interrupt line (`tcu_ext_intr_i`) seen by the trap unit. Software uses a claim/complete handshake, issued through a small configuration register port, to identify the winning source and retire it.

## Interface
- `NumSrc`, 8: number of interrupt sources. Source ids are 1..NumSrc; id 0 means "none". Legal range is 1..2**IdWidth-1.
- `IdWidth`, 4: width of claim/complete ids.
- `SyncStages`, 2: synchronizer flops per source; must be ≥ 1.
- `clk_i`  in  1  core clock.
- `rstn_i`  in  1  reset, synchronous, active-low. One clock domain; all state updates on the rising edge of `clk_i`.
- `src_i`  in  NumSrc  asynchronous interrupt lines. Bit i-1 is source id i.
- `cfg_we_i`  in  1  configuration write strobe.
- `cfg_addr_i`  in  2  register select: 0 ENABLE, 1 EDGE, 2 PENDING, 3 INSERVICE.
- `cfg_wdata_i`  in  NumSrc  write data.
- `cfg_rdata_o`  out  NumSrc  combinational read of the register selected by `cfg_addr_i`.
- `claim_i`  in  1  one-cycle claim request.
- `claim_valid_o`  out  1  one-cycle pulse, registered, the cycle after `claim_i`.
- `claim_id_o`  out  IdWidth  claimed id, valid with `claim_valid_o`, held until the next claim.
- `complete_i`  in  1  completion strobe.
- `complete_id_i`  in  IdWidth  id being completed.
- `ext_irq_o`  out  1  registered; connects to `tcu_ext_intr_i`.

## Operation
- **Synchronizer.** Each source passes through `SyncStages` flops, giving `s[i]`. An edge flop holds `s_q[i]`. The rising-edge event is `s & ~s_q`.
- **Pending set.** A level source (EDGE bit 0) sets pending while `s[i]=1` and INSERVICE[i]=0. An edge source (EDGE bit 1) sets pending on a rising-edge event, regardless of INSERVICE.
- **Eligible** = PENDING & ENABLE & ~INSERVICE.
- **Winner** = lowest set bit of Eligible, as id = bit index + 1. The winner is 0 if Eligible is 0.
- **Interrupt output.** `ext_irq_o` is registered `|Eligible`.
- **Claim.** When `claim_i=1`, the edge latches the winner into `claim_id_o` and pulses `claim_valid_o`. If the winner is non-zero, the same edge clears PENDING[w] and sets INSERVICE[w]. With no winner, the claim returns id 0 and changes no state.
- **Complete.** `complete_i` with id k in 1..NumSrc and INSERVICE[k]=1 clears INSERVICE[k]. Any other id (0, out of range, or not in service) is ignored.
- **Register writes** (`cfg_we_i`):
  - addr 0 writes ENABLE. PENDING is untouched, so a masked source stays pending.
  - addr 1 writes EDGE. It also clears PENDING for every bit whose mode changes.
  - addr 2 ORs `cfg_wdata_i` into PENDING (software trigger).
  - addr 3 is read-only; writes are ignored.
- **Simultaneous events in one edge:**
  - A claim clearing PENDING[w] and a new edge event on w: the set wins, so w stays pending.
  - Claim and complete of the same id: the claim's set of INSERVICE wins.
  - Claim and complete of different ids: both apply.
  - A PENDING software write and a claim of the same bit: the set wins.
  - ENABLE written in the same cycle as a claim: the claim uses the pre-write ENABLE.
- **Reset** (`rstn_i=0` at an edge) clears ENABLE, EDGE, PENDING, INSERVICE, all synchronizer and edge flops, `claim_id_o`, `claim_valid_o` and `ext_irq_o`. Inputs are ignored during reset.
  - A source held high across reset release is seen as a rising edge once synchronized.
  - A claim or complete in progress at reset is discarded.

## Timing
- Source to pending: `src_i` is first sampled high at edge k. `s` is high after edge k+SyncStages-1. PENDING sets at edge k+SyncStages.
- `ext_irq_o` rises at edge k+SyncStages+1 (3 cycles with default parameters), provided the source is enabled and not in service.
- A claim at edge c gives `claim_valid_o`/`claim_id_o` during cycle c+1. The PENDING/INSERVICE update is visible on `cfg_rdata_o` in cycle c+1. `ext_irq_o` reflects the new Eligible at edge c+1 (i.e. from cycle c+2).
- Complete at edge c: INSERVICE clears at c. A still-asserted level source re-pends at c+1. `ext_irq_o` rises at c+2.
- A config write at edge c is visible on `cfg_rdata_o` in cycle c+1 and on `ext_irq_o` from edge c+1.
- `cfg_rdata_o` has zero latency (combinational from registers and `cfg_addr_i`). Bits above NumSrc are not applicable because the register width is NumSrc.

## Test plan
- Reset, ENABLE=0xFF, EDGE=0x00, `src_i`=0x04 held → `ext_irq_o` high 3 cycles after first sample. Claim → id 3, PENDING=0, INSERVICE=0x04. `ext_irq_o` low. Complete id 3 with source still high → re-pends, `ext_irq_o` high 2 cycles later.
- `src_i`=0x81 level, both enabled → claims return 1, then 8, then 0. The id-0 claim changes no state.
- EDGE=0x02; pulse `src_i[1]` for 1 cycle, twice while id 2 is in service → PENDING[1] set. Claim during a coincident edge event → id 2 returned and PENDING[1] remains 1.
- ENABLE=0x00 with a source pending → `ext_irq_o` stays 0 and PENDING is kept. Write ENABLE=0x01 → `ext_irq_o` rises next cycle. Write EDGE to flip that bit → PENDING bit cleared.
- Complete with id 0, id 9, and an id not in service → INSERVICE unchanged. Claim plus complete of the same id in one cycle → INSERVICE stays set.
- Assert `rstn_i`=0 for one cycle mid-claim with PENDING=0x30 and `src_i`=0x10 held → all registers 0 and `claim_valid_o`=0. After release and ENABLE=0x10, the source pends after SyncStages cycles.
